synapse_bank: RTL

- Parametrised multi-input leaky synapse for the spiking-neuron datapath.
- Holds a programmable signed weight per presynaptic input.
- Latches spikes between time-steps. On each `step` strobe it applies exponential decay plus the sum of weights for all spiked inputs.
- Output current `out` feeds the downstream neuron membrane integrator. Replaces the fixed 3-input, 18-bit synapse.

---
 rtl/synapse_bank_if.sv | 32 +++
 rtl/synapse_bank.sv | 108 ++++++++++
 2 files changed

// File: rtl/synapse_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synapse_bank_if : control / weight-write / current bus of the bank   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface synapse_bank_if #(
  parameter int N_IN = 8,
  parameter int W    = 18
);
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic                step;
  logic [N_IN-1:0]     spike;
  logic                clear;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic signed [W-1:0] wr_data;
  logic signed [W-1:0] out;
  logic                out_valid;
  logic                sat;

  modport master (
    output step, spike, clear, wr_en, wr_addr, wr_data,
    input  out, out_valid, sat
  );

  modport slave (
    input  step, spike, clear, wr_en, wr_addr, wr_data,
    output out, out_valid, sat
  );
endinterface
`default_nettype wire

// File: rtl/synapse_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synapse_bank : N_IN-input leaky synapse, decay + weighted spike sum   |
// | Optional clamp: define SYNAPSE_BANK_SAT_EN.  Rev 1.0                  |
// +----------------------------------------------------------------------+
module synapse_bank #(
  parameter int N_IN        = 8,
  parameter int W           = 18,
  parameter int DECAY_SHIFT = 4
) (
  input  wire            clock,
  input  wire            reset,
  synapse_bank_if.slave  bus
);
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WW = W + AW + 2;

  logic signed [W-1:0]  r_weight [N_IN];
  logic [N_IN-1:0]      r_pending;
  logic signed [W-1:0]  r_out;
  logic                 r_valid;
  logic                 r_sat;

  logic [N_IN-1:0]      w_eff;
  logic signed [WW-1:0] w_v;
  logic signed [WW-1:0] w_decay;
  logic signed [WW-1:0] w_sum;
  logic signed [WW-1:0] w_total;
  logic signed [W-1:0]  w_next;
  logic                 w_sat;

  // A spike coincident with the step strobe joins that step's update
  assign w_eff   = r_pending | bus.spike;
  assign w_v     = {{(WW-W){r_out[W-1]}}, r_out};
  assign w_decay = (-w_v) >>> DECAY_SHIFT;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_eff[i]) begin
        w_sum = w_sum + {{(WW-W){r_weight[i][W-1]}}, r_weight[i]};
      end
    end
  end

  assign w_total = w_v + w_decay + w_sum;

`ifdef SYNAPSE_BANK_SAT_EN
  localparam logic signed [WW-1:0] c_max = {{(WW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WW-1:0] c_min = {{(WW-W+1){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    w_next = w_total[W-1:0];
    w_sat  = 1'b0;
    if (w_total > c_max) begin
      w_next = c_max[W-1:0];
      w_sat  = 1'b1;
    end else if (w_total < c_min) begin
      w_next = c_min[W-1:0];
      w_sat  = 1'b1;
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_total[WW-1:W];
  assign w_next      = w_total[W-1:0];
  assign w_sat       = 1'b0;
`endif

  // Weight file: the step in the same cycle still sees the old value
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) begin
        r_weight[i] <= '0;
      end
    end else if (bus.wr_en && (int'(bus.wr_addr) < N_IN)) begin
      r_weight[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Priority: reset, then clear, then step
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
    end else if (bus.clear) begin
      r_pending <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
    end else if (bus.step) begin
      r_pending <= '0;
      r_out     <= w_next;
      r_valid   <= 1'b1;
      r_sat     <= w_sat;
    end else begin
      r_pending <= r_pending | bus.spike;
      r_valid   <= 1'b0;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.sat       = r_sat;
endmodule
`default_nettype wire
